// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the parametrised convolution layers.
package conv_pkg;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } conv_state_e;

  localparam int unsigned DefInCh  = 3;
  localparam int unsigned DefOutCh = 3;
  localparam int unsigned DefTaps  = 25;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefWW    = 8;
  localparam int unsigned DefAccW  = 32;
  localparam int unsigned DefShift = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Arithmetic right shift then clamp into a signed field of 'width' bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                    input int unsigned       shift,
                                                    input int unsigned       width,
                                                    output logic             clipped);
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    shifted = acc >>> shift;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    clipped = 1'b0;
    if (shifted > max_v) begin
      clipped = 1'b1;
      return max_v;
    end else if (shifted < min_v) begin
      clipped = 1'b1;
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output-channel lane: weight store, window accumulator and saturating/ReLU output stage.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int unsigned IN_CH  = DefInCh,
  parameter int unsigned TAPS   = DefTaps,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned W_W    = DefWW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned SHIFT  = DefShift,
  localparam int unsigned TAP_W = (TAPS > 1) ? clog2(TAPS) : 1,
  localparam int unsigned IDX_W = (IN_CH * TAPS > 1) ? clog2(IN_CH * TAPS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      w_we_i,
  input  logic [IDX_W-1:0]          w_idx_i,
  input  logic signed [W_W-1:0]     w_data_i,
  input  logic                      samp_en_i,
  input  logic                      last_tap_i,
  input  logic                      clear_i,
  input  logic [TAP_W-1:0]          tap_i,
  input  logic [IN_CH*DATA_W-1:0]   data_i,
  input  logic                      relu_en_i,
  output logic [DATA_W-1:0]         out_o,
  output logic                      sat_o
);

  logic signed [W_W-1:0]        w_q [IN_CH*TAPS];
  logic signed [ACC_W-1:0]      acc_q, acc_d, acc_next;
  logic [DATA_W-1:0]            out_q, out_d;
  logic                         sat_q, sat_d;
  logic [IDX_W-1:0]             idx;
  logic signed [DATA_W+W_W-1:0] prod;
  logic signed [ACC_W-1:0]      prod_ext;
  logic signed [63:0]           acc_wide;
  logic signed [63:0]           sat_res;
  logic                         clip;

  // Weights survive reset; only the loader overwrites them.
  always_ff @(posedge clk_i) begin
    if (w_we_i) w_q[w_idx_i] <= w_data_i;
  end

  always_comb begin
    acc_next = acc_q;
    idx      = '0;
    prod     = '0;
    prod_ext = '0;
    for (int c = 0; c < IN_CH; c++) begin
      idx      = IDX_W'(c * TAPS) + IDX_W'(tap_i);
      prod     = $signed(data_i[c*DATA_W +: DATA_W]) * w_q[idx];
      prod_ext = prod;
      acc_next = acc_next + prod_ext;
    end
  end

  always_comb begin
    acc_wide = acc_next;
    clip     = 1'b0;
    sat_res  = sat_shift(acc_wide, SHIFT, DATA_W, clip);
    acc_d    = acc_q;
    out_d    = out_q;
    sat_d    = 1'b0;
    if (clear_i) begin
      acc_d = '0;
    end else if (samp_en_i) begin
      if (last_tap_i) begin
        acc_d = '0;
        out_d = (relu_en_i && (sat_res < 64'sd0)) ? '0 : sat_res[DATA_W-1:0];
        sat_d = clip;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      sat_q <= sat_d;
    end
  end

  assign out_o = out_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/conv_layer_param.sv
// Parametrised convolution layer: serial weight loader, tap sequencer and OUT_CH MAC lanes.
module conv_layer_param
  import conv_pkg::*;
#(
  parameter int unsigned IN_CH  = DefInCh,
  parameter int unsigned OUT_CH = DefOutCh,
  parameter int unsigned TAPS   = DefTaps,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned W_W    = DefWW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned SHIFT  = DefShift
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [IN_CH*DATA_W-1:0]  data_in,
  input  logic                     weight_valid,
  input  logic [W_W-1:0]           filter,
  input  logic                     weight_reload,
  input  logic                     relu_en,
  output logic [OUT_CH*DATA_W-1:0] conv_out,
  output logic                     conv_valid,
  output logic                     weight_done,
  output logic                     sat_flag
);

  localparam int unsigned LaneWords = IN_CH * TAPS;
  localparam int unsigned Total     = OUT_CH * LaneWords;
  localparam int unsigned CntW      = (Total > 1) ? clog2(Total) : 1;
  localparam int unsigned TapW      = (TAPS > 1) ? clog2(TAPS) : 1;
  localparam int unsigned IdxW      = (LaneWords > 1) ? clog2(LaneWords) : 1;

  conv_state_e     state_q, state_d;
  logic [CntW-1:0] weight_cnt_q, weight_cnt_d;
  logic [TapW-1:0] tap_cnt_q, tap_cnt_d;
  logic            weight_done_q, weight_done_d;
  logic            conv_valid_q, conv_valid_d;
  logic            samp_en, last_tap, lane_clear, load_we;
  logic [31:0]     cnt_ext;
  logic [OUT_CH-1:0] lane_we, lane_sat;

  always_comb begin
    state_d       = state_q;
    weight_cnt_d  = weight_cnt_q;
    tap_cnt_d     = tap_cnt_q;
    weight_done_d = weight_done_q;
    conv_valid_d  = 1'b0;
    samp_en       = 1'b0;
    lane_clear    = 1'b0;
    load_we       = 1'b0;
    last_tap      = (tap_cnt_q == TapW'(TAPS - 1));
    unique case (state_q)
      StLoad: begin
        if (weight_valid) begin
          load_we = 1'b1;
          if (weight_cnt_q == CntW'(Total - 1)) begin
            weight_cnt_d  = '0;
            weight_done_d = 1'b1;
            state_d       = StRun;
          end else begin
            weight_cnt_d = weight_cnt_q + CntW'(1);
          end
        end
      end
      StRun: begin
        // Reload wins over a same-cycle sample and discards the partial window.
        if (weight_reload) begin
          lane_clear    = 1'b1;
          tap_cnt_d     = '0;
          weight_cnt_d  = '0;
          weight_done_d = 1'b0;
          state_d       = StLoad;
        end else if (i_valid) begin
          samp_en = 1'b1;
          if (last_tap) begin
            tap_cnt_d    = '0;
            conv_valid_d = 1'b1;
          end else begin
            tap_cnt_d = tap_cnt_q + TapW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= StLoad;
      weight_cnt_q  <= '0;
      tap_cnt_q     <= '0;
      weight_done_q <= 1'b0;
      conv_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      weight_cnt_q  <= weight_cnt_d;
      tap_cnt_q     <= tap_cnt_d;
      weight_done_q <= weight_done_d;
      conv_valid_q  <= conv_valid_d;
    end
  end

  assign cnt_ext = 32'(weight_cnt_q);

  for (genvar f = 0; f < OUT_CH; f++) begin : g_lane
    localparam int unsigned Base = f * LaneWords;

    // Filter-major stream: lane f owns the contiguous slice [Base, Base+LaneWords).
    assign lane_we[f] = load_we && (cnt_ext >= Base) && (cnt_ext < Base + LaneWords);

    conv_mac_lane #(
      .IN_CH  (IN_CH),
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .W_W    (W_W),
      .ACC_W  (ACC_W),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk_i      (i_clk),
      .rst_ni     (i_rst),
      .w_we_i     (lane_we[f]),
      .w_idx_i    (IdxW'(cnt_ext - Base)),
      .w_data_i   (filter),
      .samp_en_i  (samp_en),
      .last_tap_i (last_tap),
      .clear_i    (lane_clear),
      .tap_i      (tap_cnt_q),
      .data_i     (data_in),
      .relu_en_i  (relu_en),
      .out_o      (conv_out[f*DATA_W +: DATA_W]),
      .sat_o      (lane_sat[f])
    );
  end

  assign conv_valid  = conv_valid_q;
  assign weight_done = weight_done_q;
  assign sat_flag    = |lane_sat;

endmodule
